// File: rtl/fetch_sequencer_pkg.sv
// cpu_pkg: opcodes, sequencer state and next-PC select encodings shared by the fetch path.
package cpu_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_OP_W = 3;
  localparam int DEF_CNT_W = 8;
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_INC1, PC_INC2, PC_LOAD} pc_sel_t;
  function automatic logic is_ctrl(logic [2:0] op);
    return op == OP_HLT || op == OP_SKZ || op == OP_JMP;
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, datapath handshake and status signals of the sequencer.
interface fetch_sequencer_if import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W = DEF_OP_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic [OP_W-1:0] Opcode;
  logic [ADDR_W-1:0] Address;
  logic Acc_Zero;
  logic Exec_Ready;
  logic Resume;
  logic [ADDR_W-1:0] PC;
  logic Exec_Valid;
  logic [OP_W-1:0] Exec_Op;
  logic [ADDR_W-1:0] Exec_Addr;
  logic Halted;
  logic [CNT_W-1:0] Retired;
  modport master (
    input Opcode, Address, Acc_Zero, Exec_Ready, Resume,
    output PC, Exec_Valid, Exec_Op, Exec_Addr, Halted, Retired
  );
  modport slave (
    output Opcode, Address, Acc_Zero, Exec_Ready, Resume,
    input PC, Exec_Valid, Exec_Op, Exec_Addr, Halted, Retired
  );
endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// pc_next: combinational next-PC selector (hold / +1 / +2 / load), wrapping modulo 2^ADDR_W.
module pc_next import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] load_addr,
  input  pc_sel_t           sel,
  output logic [ADDR_W-1:0] nxt
);
  always_comb begin
    nxt = sel == PC_LOAD ? load_addr
        : pc + ADDR_W'(sel == PC_INC2 ? 2 : sel == PC_INC1 ? 1 : 0);
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode FSM issuing datapath ops over valid/ready and resolving HLT/SKZ/JMP locally.
module fetch_sequencer import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W = DEF_OP_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic Clk,
  input logic Reset,
  fetch_sequencer_if.master bus
);
  state_t state, state_nxt;
  pc_sel_t sel;
  logic retire, dec, ctrl, fire;
  logic [ADDR_W-1:0] pc, pc_nxt, addr_q;
  logic [OP_W-1:0] op_q;
  logic [CNT_W-1:0] retired;
  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc(pc),
    .load_addr(bus.Address),
    .sel(sel),
    .nxt(pc_nxt)
  );
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_FETCH;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = bus.Opcode == OP_HLT ? S_HALT : ctrl ? S_FETCH : S_EXEC;
      S_EXEC:   state_nxt = bus.Exec_Ready ? S_FETCH : S_EXEC;
      S_HALT:   state_nxt = bus.Resume ? S_FETCH : S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end
  always_comb begin
    dec = state == S_DECODE;
    ctrl = is_ctrl(3'(bus.Opcode));
    fire = state == S_EXEC && bus.Exec_Ready;
    sel = dec ? (bus.Opcode == OP_JMP ? PC_LOAD
               : bus.Opcode == OP_SKZ ? (bus.Acc_Zero ? PC_INC2 : PC_INC1) : PC_HOLD)
        : (fire || (state == S_HALT && bus.Resume)) ? PC_INC1 : PC_HOLD;
    retire = (dec && ctrl) || fire;
    bus.Exec_Valid = state == S_EXEC;
    bus.Halted = state == S_HALT;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= '0;
      op_q <= '0;
      addr_q <= '0;
      retired <= '0;
    end else begin
      pc <= pc_nxt;
      if (dec && !ctrl) begin
        op_q <= bus.Opcode;
        addr_q <= bus.Address;
      end
      if (retire) retired <= retired + 1'b1;
    end
  end
  assign bus.PC = pc;
  assign bus.Exec_Op = op_q;
  assign bus.Exec_Addr = addr_q;
  assign bus.Retired = retired;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch and sequencing controller for the 8-bit CPU; it is the initiator on the instruction-memory interface.
- Drives the 5-bit PC into the instruction memory, which returns Opcode/Address registered one cycle later.
- Decodes control-flow opcodes itself: HLT, SKZ, JMP.
- Hands all other instructions to the datapath over a valid/ready handshake.
- Sits between instruction memory and the ALU/accumulator/data-memory datapath.

Parameters:
ADDR_W, 5, PC and operand address width (memory depth 2^ADDR_W)
OP_W, 3, opcode width
CNT_W, 8, retired-instruction counter width

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Opcode  input  OP_W  opcode from instruction memory, valid the cycle after PC is presented
Address  input  ADDR_W  operand field from instruction memory, same timing as Opcode
Acc_Zero  input  1  accumulator-is-zero flag from datapath, sampled in DECODE
Exec_Ready  input  1  datapath accepts/completes the issued instruction
Resume  input  1  one-cycle pulse that leaves HALT
PC  output  ADDR_W  program counter, registered
Exec_Valid  output  1  instruction in Exec_Op/Exec_Addr awaiting datapath
Exec_Op  output  OP_W  latched opcode for datapath
Exec_Addr  output  ADDR_W  latched operand address for datapath
Halted  output  1  high while in HALT
Retired  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Clocking and reset: single clock Clk; Reset is synchronous, active-high.
- Reset values: PC=0, state=FETCH, Exec_Valid=0, Exec_Op=0, Exec_Addr=0, Halted=0, Retired=0.
- Reset mid-operation: Reset has priority over everything, including a pending handshake or a Resume pulse.
- Opcode encoding: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- FETCH (1 cycle): PC held stable so the memory registers the instruction at the end of this cycle. Next state is DECODE.
- DECODE (1 cycle): Opcode/Address are valid; the sequencer ignores them in every other state.
  - HLT: goto HALT; PC unchanged; Retired+1.
  - JMP: PC<=Address; goto FETCH; Retired+1.
  - SKZ: PC<=PC+2 if Acc_Zero else PC+1; goto FETCH; Retired+1.
  - Others: latch Exec_Op/Exec_Addr, assert Exec_Valid; goto EXEC.
- EXEC:
  - Exec_Valid held high; Exec_Op/Exec_Addr held stable until the handshake.
  - The cycle Exec_Valid && Exec_Ready is high completes the handshake.
  - On that edge: Exec_Valid<=0, PC<=PC+1, Retired+1, goto FETCH.
  - If Exec_Ready is low, stay in EXEC indefinitely.
- HALT:
  - Halted=1; PC frozen; no Exec_Valid.
  - A Resume pulse gives PC<=PC+1, Halted<=0, goto FETCH.
  - Resume in any other state is ignored.
- PC arithmetic is modulo 2^ADDR_W: 31+1=0, 30+2=0, 31+2=1.
- Retired wraps at 2^CNT_W.
- Latency:
  - JMP/SKZ/HLT: 2 cycles.
  - Datapath instruction with Exec_Ready high: 3 cycles minimum.
- Exec_Ready asserted outside EXEC is ignored.
- Because the memory also resets its output to opcode 0, the sequencer never decodes in the cycle immediately after Reset; FETCH always precedes DECODE.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_HLT..OP_JMP;
  - state encoding S_FETCH, S_DECODE, S_EXEC, S_HALT;
  - ADDR_W/OP_W defaults.
- A sub-module is natural: pc_next, the combinational next-PC selector (hold / +1 / +2 / load) with modulo wrap. The FSM, latches and counter stay in fetch_sequencer.

Test Plan:
- Bench uses a memory model with one-cycle registered latency.
- Reset and first fetch: hold Reset 2 cycles; mem[0]=JMP 30, mem[30]=JMP 3 -> PC sequence 0,0,30,30,3; Retired=2; Exec_Valid never high.
- Datapath handshake: mem[3]=LDA 26; Exec_Ready low 3 cycles then high -> Exec_Valid high 4 cycles with Exec_Op=5, Exec_Addr=26 stable; PC becomes 4 on the handshake edge; Retired+1.
- SKZ branches: PC=10 with SKZ, Acc_Zero=1 -> PC=12; repeat with Acc_Zero=0 -> PC=11; SKZ at PC=31 with Acc_Zero=1 -> PC=1.
- HLT/Resume: HLT at PC=9 -> Halted=1, PC stays 9 for 20 cycles; Exec_Ready pulses have no effect; Resume pulse -> Halted=0, PC=10 next cycle, FETCH.
- Wrap and reset mid-EXEC:
  - ADD at PC=31 with Exec_Ready=1 -> PC=0.
  - Separately, assert Reset while in EXEC with Exec_Valid=1 -> next cycle PC=0, Exec_Valid=0, Retired=0.
